// File: rtl/fb_mem_scheduler_if.sv
// Bus bundle between game/VGA logic and the frame-buffer port scheduler.
// master = game/VGA side, slave = scheduler side.
interface fb_mem_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic              vga_active;
  logic [ADDR_W-1:0] vga_addr;
  logic              vblank;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [2:0]        mem_wdata;

  modport master (
    output vga_active, vga_addr, vblank, wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  vga_active, vga_addr, vblank, wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_mem_scheduler.sv
// Single-port frame-buffer arbiter: scanout reads > clear engine > buffered pixel writes.
// Optional FB_VBLANK_ONLY_EN restricts all RAM writes to vertical blanking.
module fb_mem_scheduler #(
  parameter int         FB_WORDS  = 19200,
  parameter int         ADDR_W    = 16,
  parameter int         FIFO_LOG2 = 3,
  parameter logic [2:0] CLR_CODE  = 3'd0
) (
  input logic               dclk,
  input logic               clr,
  fb_mem_scheduler_if.slave bus
);

  localparam int                  DEPTH     = 1 << FIFO_LOG2;
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(FB_WORDS - 1);
  localparam logic [ADDR_W-1:0]   ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]   ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = {{(FIFO_LOG2-1){1'b0}}, 1'b1};
  localparam logic [FIFO_LOG2:0]  CNT_ONE   = {{FIFO_LOG2{1'b0}}, 1'b1};
  localparam logic [FIFO_LOG2:0]  CNT_ZERO  = {(FIFO_LOG2+1){1'b0}};
  localparam logic [FIFO_LOG2:0]  CNT_FULL  = (FIFO_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        data;
  } entry_t;

  state_e               state_q, state_d;
  entry_t               fifo_q [DEPTH];
  entry_t               fifo_d [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 slot_free_s, push_s, pop_s, clr_wr_s, fifo_empty_s;

`ifdef FB_VBLANK_ONLY_EN
  assign slot_free_s = bus.vblank & ~bus.vga_active;
`else
  logic unused_vblank_s;
  assign unused_vblank_s = bus.vblank;
  assign slot_free_s     = ~bus.vga_active;
`endif

  assign fifo_empty_s = (count_q == CNT_ZERO);
  assign push_s       = bus.wr_valid & ready_q;
  assign bus.wr_ready = ready_q;
  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;

  // Port mux: scanout owns the address whenever active, independent of state.
  always_comb begin
    bus.mem_addr  = bus.vga_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 3'd0;
    pop_s         = 1'b0;
    clr_wr_s      = 1'b0;
    if (bus.vga_active) begin
      bus.mem_addr = bus.vga_addr;
    end else if ((state_q == CLEAR) && slot_free_s) begin
      bus.mem_addr  = cnt_q;
      bus.mem_wdata = CLR_CODE;
      bus.mem_we    = 1'b1;
      clr_wr_s      = 1'b1;
    end else if ((state_q != CLEAR) && !fifo_empty_s && slot_free_s) begin
      bus.mem_addr  = fifo_q[rd_ptr_q].addr;
      bus.mem_wdata = fifo_q[rd_ptr_q].data;
      bus.mem_we    = 1'b1;
      pop_s         = 1'b1;
    end else begin
      bus.mem_we = 1'b0;
    end
  end

  // FIFO bookkeeping, clear sequencing and next-state logic.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    done_d   = 1'b0;

    if (push_s) begin
      fifo_d[wr_ptr_q] = '{addr: bus.wr_addr, data: bus.wr_data};
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Requests arriving while busy collapse into a single pending clear.
    if (bus.clr_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = (count_d == CNT_ZERO) ? CLEAR : DRAIN;
          cnt_d   = ADDR_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (count_d == CNT_ZERO) begin
          state_d = CLEAR;
          cnt_d   = ADDR_ZERO;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        if (clr_wr_s && (cnt_q == LAST_ADDR)) begin
          done_d = 1'b1;
          cnt_d  = ADDR_ZERO;
          if (pend_q || bus.clr_req) begin
            state_d = CLEAR;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (clr_wr_s) begin
          cnt_d = cnt_q + ADDR_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (count_d != CNT_FULL) && (state_d != DRAIN);
  end

  // State and FIFO registers; reset abandons any clear and discards buffered writes.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      wr_ptr_q <= {FIFO_LOG2{1'b0}};
      rd_ptr_q <= {FIFO_LOG2{1'b0}};
      count_q  <= CNT_ZERO;
      cnt_q    <= ADDR_ZERO;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '{addr: ADDR_ZERO, data: 3'd0};
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fb_mem_scheduler.sv
// Directed self-checking bench for fb_mem_scheduler (default build, vblank ignored).
module tb_fb_mem_scheduler;
  localparam int FB_WORDS = 19200;

  logic dclk = 1'b0;
  logic clr  = 1'b1;
  always #5 dclk = ~dclk;

  fb_mem_scheduler_if #(.ADDR_W(16)) bus_if ();

  fb_mem_scheduler #(
    .FB_WORDS(FB_WORDS), .ADDR_W(16), .FIFO_LOG2(3), .CLR_CODE(3'd0)
  ) dut (
    .dclk(dclk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  int          check_cnt = 0;
  int          error_cnt = 0;
  logic [18:0] wlog[$];
  int          done_pos[$];

  // Record every RAM write and the write-log position of each clr_done pulse.
  always @(negedge dclk) begin
    if (!clr && bus_if.clr_done === 1'b1) done_pos.push_back(wlog.size());
    if (!clr && bus_if.mem_we === 1'b1) wlog.push_back({bus_if.mem_addr, bus_if.mem_wdata});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] ent(input logic [15:0] a, input logic [2:0] d);
    return {a, d};
  endfunction

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic sample();
    @(negedge dclk);
    #1;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [2:0] d);
    logic ok;
    ok = 1'b0;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = a;
    bus_if.wr_data  = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      sample();
      ok = bus_if.wr_ready;
      step();
    end
    bus_if.wr_valid = 1'b0;
    if (!ok) check_val("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int b, d0, bad, acc, viol, gaps;
    logic ok;
    bus_if.vga_active = 1'b0;
    bus_if.vga_addr   = 16'd0;
    bus_if.vblank     = 1'b0;
    bus_if.wr_valid   = 1'b0;
    bus_if.wr_addr    = 16'd0;
    bus_if.wr_data    = 3'd0;
    bus_if.clr_req    = 1'b0;

    // Reset values
    repeat (2) step();
    sample();
    check_val("rst_busy", bus_if.clr_busy, 1'b0);
    check_val("rst_done", bus_if.clr_done, 1'b0);
    check_val("rst_we", bus_if.mem_we, 1'b0);
    step();
    clr = 1'b0;
    sample();
    check_val("rst_ready", bus_if.wr_ready, 1'b1);
    step();

    // Write while idle: one-cycle latency to the RAM port
    push_wr(16'h0010, 3'd3);
    sample();
    check_val("idle_we", bus_if.mem_we, 1'b1);
    check_val("idle_addr", bus_if.mem_addr, 16'h0010);
    check_val("idle_data", bus_if.mem_wdata, 3'd3);
    step();
    sample();
    check_val("idle_empty_after", bus_if.mem_we, 1'b0);
    step();

    // Scanout priority for 200 cycles with 5 buffered writes
    bus_if.vga_active = 1'b1;
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      bus_if.vga_addr = 16'h4000 + 16'(i);
      if (i < 5) begin
        bus_if.wr_valid = 1'b1;
        bus_if.wr_addr  = 16'h0100 + 16'(i);
        bus_if.wr_data  = 3'(i + 1);
      end else begin
        bus_if.wr_valid = 1'b0;
      end
      sample();
      if (bus_if.mem_we !== 1'b0 || bus_if.mem_addr !== 16'h4000 + 16'(i)) viol++;
      step();
    end
    check_val("scan_priority_viol", viol, 0);
    bus_if.vga_active = 1'b0;
    for (int j = 0; j < 5; j++) begin
      sample();
      check_val("scan_drain_we", bus_if.mem_we, 1'b1);
      check_val("scan_drain_ent", {bus_if.mem_addr, bus_if.mem_wdata}, ent(16'h0100 + 16'(j), 3'(j + 1)));
      step();
    end
    sample();
    check_val("scan_drain_done", bus_if.mem_we, 1'b0);
    step();

    // FIFO full: 9th request refused
    bus_if.vga_active = 1'b1;
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      bus_if.wr_valid = 1'b1;
      bus_if.wr_addr  = 16'h0200 + 16'(i);
      bus_if.wr_data  = 3'(i);
      sample();
      if (i == 7) check_val("full_ready_8th", bus_if.wr_ready, 1'b1);
      if (i == 8) check_val("full_ready_9th", bus_if.wr_ready, 1'b0);
      if (bus_if.wr_ready) acc++;
      step();
    end
    bus_if.wr_valid = 1'b0;
    check_val("full_accepted", acc, 8);
    b = wlog.size();
    bus_if.vga_active = 1'b0;
    repeat (12) step();
    check_val("full_drained", wlog.size() - b, 8);
    if (wlog.size() >= b + 8) begin
      check_val("full_first", wlog[b], ent(16'h0200, 3'd0));
      check_val("full_last", wlog[b + 7], ent(16'h0207, 3'd7));
    end

    // Clear ordering: 2 writes, clr_req, 1 write
    bus_if.vga_active = 1'b1;
    bus_if.wr_valid   = 1'b1;
    bus_if.wr_addr    = 16'h0300;
    bus_if.wr_data    = 3'd5;
    step();
    bus_if.wr_addr = 16'h0301;
    bus_if.wr_data = 3'd6;
    step();
    bus_if.wr_valid = 1'b0;
    bus_if.clr_req  = 1'b1;
    step();
    bus_if.clr_req = 1'b0;
    sample();
    check_val("drain_busy", bus_if.clr_busy, 1'b1);
    check_val("drain_closed", bus_if.wr_ready, 1'b0);
    step();
    b  = wlog.size();
    d0 = done_pos.size();
    bus_if.vga_active = 1'b0;
    bus_if.wr_valid   = 1'b1;
    bus_if.wr_addr    = 16'h0302;
    bus_if.wr_data    = 3'd7;
    for (int n = 0; n < 25000; n++) begin
      sample();
      if (bus_if.wr_valid && bus_if.wr_ready) begin
        step();
        bus_if.wr_valid = 1'b0;
      end else begin
        step();
      end
      if (done_pos.size() > d0 && wlog.size() >= b + FB_WORDS + 3) break;
    end
    check_val("ord_wr3_accepted", bus_if.wr_valid, 1'b0);
    check_val("ord_count", wlog.size() - b, FB_WORDS + 3);
    check_val("ord_done_cnt", done_pos.size() - d0, 1);
    if (wlog.size() >= b + FB_WORDS + 3 && done_pos.size() > d0) begin
      bad = 0;
      for (int k = 0; k < FB_WORDS; k++) if (wlog[b + 2 + k] !== ent(16'(k), 3'd0)) bad++;
      check_val("ord_w1", wlog[b], ent(16'h0300, 3'd5));
      check_val("ord_w2", wlog[b + 1], ent(16'h0301, 3'd6));
      check_val("ord_clear_seq", bad, 0);
      check_val("ord_w3", wlog[b + FB_WORDS + 2], ent(16'h0302, 3'd7));
      check_val("ord_done_pos", done_pos[d0] - b, FB_WORDS + 2);
    end
    sample();
    check_val("ord_busy_end", bus_if.clr_busy, 1'b0);
    step();

    // Double clear: second request at cycle 100 of the first
    b  = wlog.size();
    d0 = done_pos.size();
    gaps = 0;
    bus_if.clr_req = 1'b1;
    step();
    bus_if.clr_req = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      sample();
      if (done_pos.size() - d0 >= 2) break;
      if (!bus_if.clr_busy) gaps++;
      step();
      bus_if.clr_req = (i == 99);
    end
    bus_if.clr_req = 1'b0;
    check_val("dbl_busy_gaps", gaps, 0);
    check_val("dbl_done_cnt", done_pos.size() - d0, 2);
    check_val("dbl_writes", wlog.size() - b, 2 * FB_WORDS);
    check_val("dbl_busy_end", bus_if.clr_busy, 1'b0);
    if (wlog.size() >= b + 2 * FB_WORDS && done_pos.size() - d0 >= 2) begin
      bad = 0;
      for (int k = 0; k < 2 * FB_WORDS; k++) if (wlog[b + k] !== ent(16'(k % FB_WORDS), 3'd0)) bad++;
      check_val("dbl_seq", bad, 0);
      check_val("dbl_done1_pos", done_pos[d0] - b, FB_WORDS);
      check_val("dbl_done2_pos", done_pos[d0 + 1] - b, 2 * FB_WORDS);
    end
    step();

    // Reset mid-clear, with one write buffered
    bus_if.clr_req = 1'b1;
    step();
    bus_if.clr_req  = 1'b0;
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = 16'h0400;
    bus_if.wr_data  = 3'd2;
    step();
    bus_if.wr_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      sample();
      if (bus_if.mem_we && bus_if.mem_addr == 16'd5000) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_val("rst_reach_5000", ok, 1'b1);
    clr = 1'b1;
    #1;
    check_val("arst_busy", bus_if.clr_busy, 1'b0);
    check_val("arst_done", bus_if.clr_done, 1'b0);
    check_val("arst_we", bus_if.mem_we, 1'b0);
    check_val("arst_ready", bus_if.wr_ready, 1'b1);
    step();
    step();
    clr = 1'b0;
    b = wlog.size();
    repeat (3) step();
    check_val("arst_fifo_flushed", wlog.size() - b, 0);
    bus_if.clr_req = 1'b1;
    step();
    bus_if.clr_req = 1'b0;
    sample();
    check_val("arst_restart_we", bus_if.mem_we, 1'b1);
    check_val("arst_restart_addr", bus_if.mem_addr, 16'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end
endmodule
